// File: rtl/sd_uart_pkg.sv
// Shared constants and types for the SD-over-UART controller.
// Covers frame markers, host command bytes and the TX framing state set.
package sd_uart_pkg;

  localparam int unsigned PAYLOAD_BYTES = 16;
  localparam logic [7:0]  START_BYTE    = 8'hA5;

  localparam logic [7:0] CMD_RESET         = 8'h20;
  localparam logic [7:0] CMD_STOP          = 8'h25;
  localparam logic [7:0] CMD_WRITE         = 8'h4A;
  localparam logic [7:0] CMD_READ          = 8'h7A;
  localparam logic [7:0] CMD_ERASE         = 8'hF0;
  localparam logic [7:0] CMD_GET_SD_INFO   = 8'h15;
  localparam logic [7:0] CMD_GET_CTRL_INFO = 8'h1B;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_CMD   = 3'd2;
  localparam logic [2:0] ST_LEN   = 3'd3;
  localparam logic [2:0] ST_DATA  = 3'd4;
  localparam logic [2:0] ST_CSUM  = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  // The enum keeps the legacy encodings so existing debug tooling still decodes it
  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    CMD   = ST_CMD,
    LEN   = ST_LEN,
    DATA  = ST_DATA,
    CSUM  = ST_CSUM,
    DONE  = ST_DONE
  } tx_state_t;

endpackage

// File: rtl/sd_uart_rr_arb.sv
// Two-way round-robin picker: the source named by rr_ptr wins when both request.
// Purely combinational; the pointer itself lives in the parent.
module sd_uart_rr_arb (
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic       winner,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    winner = req[rr_ptr] ? rr_ptr : ~rr_ptr;
  end

endmodule

// File: rtl/sd_uart_tx_arbiter.sv
// Shares one UART transmitter between the command responder and the status reporter.
// Each grant is framed as START_BYTE, cmd, len, payload (MSB first), XOR checksum.
module sd_uart_tx_arbiter #(
  parameter int unsigned PAYLOAD_BYTES = 16,
  parameter logic [7:0]  START_BYTE    = 8'hA5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 req,
  input  logic [7:0]                 req_cmd0,
  input  logic [4:0]                 req_len0,
  input  logic [8*PAYLOAD_BYTES-1:0] req_data0,
  input  logic [7:0]                 req_cmd1,
  input  logic [4:0]                 req_len1,
  input  logic [8*PAYLOAD_BYTES-1:0] req_data1,
  output logic [1:0]                 grant,
  output logic [1:0]                 done,
  output logic                       busy,
  input  logic                       tx_ready,
  output logic                       tx_en,
  output logic [7:0]                 tx_data
);
  import sd_uart_pkg::*;

  localparam int unsigned DW      = 8 * PAYLOAD_BYTES;
  localparam logic [4:0]  MAX_LEN = 5'(PAYLOAD_BYTES);

  tx_state_t       state;
  logic            rr_ptr;
  logic            owner;
  logic            win;
  logic            win_valid;
  logic [7:0]      cmd_q;
  logic [4:0]      len_q;
  logic [4:0]      cnt;
  logic [DW-1:0]   data_q;
  logic [7:0]      csum;
  logic [7:0]      csum_next;
  logic            accept;
  logic [7:0]      sel_cmd;
  logic [4:0]      sel_len;
  logic [DW-1:0]   sel_data;

  sd_uart_rr_arb u_arb (
    .req    (req),
    .rr_ptr (rr_ptr),
    .winner (win),
    .valid  (win_valid)
  );

  always_comb begin
    sel_cmd   = win ? req_cmd1  : req_cmd0;
    sel_len   = win ? req_len1  : req_len0;
    sel_data  = win ? req_data1 : req_data0;
    if (sel_len > MAX_LEN) sel_len = MAX_LEN;
    accept    = tx_en && tx_ready;
    // tx_data always holds the byte being accepted, so it feeds the running checksum
    csum_next = csum ^ tx_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rr_ptr  <= 1'b0;
      owner   <= 1'b0;
      grant   <= '0;
      done    <= '0;
      busy    <= 1'b0;
      tx_en   <= 1'b0;
      tx_data <= '0;
      cmd_q   <= '0;
      len_q   <= '0;
      cnt     <= '0;
      data_q  <= '0;
      csum    <= '0;
    end else begin
      grant <= '0;
      done  <= '0;
      case (state)
        IDLE: if (win_valid) begin
          grant[win] <= 1'b1;
          owner      <= win;
          rr_ptr     <= ~win;
          cmd_q      <= sel_cmd;
          len_q      <= sel_len;
          data_q     <= sel_data;
          csum       <= '0;
          cnt        <= '0;
          busy       <= 1'b1;
          tx_en      <= 1'b1;
          tx_data    <= START_BYTE;
          state      <= START;
        end
        START: if (accept) begin
          tx_data <= cmd_q;
          state   <= CMD;
        end
        CMD: if (accept) begin
          csum    <= csum_next;
          tx_data <= {3'b000, len_q};
          state   <= LEN;
        end
        LEN: if (accept) begin
          csum <= csum_next;
          if (len_q == 5'd0) begin
            tx_data <= csum_next;
            state   <= CSUM;
          end else begin
            tx_data <= data_q[DW-1 -: 8];
            data_q  <= data_q << 8;
            state   <= DATA;
          end
        end
        DATA: if (accept) begin
          csum <= csum_next;
          if (cnt == len_q - 5'd1) begin
            tx_data <= csum_next;
            state   <= CSUM;
          end else begin
            tx_data <= data_q[DW-1 -: 8];
            data_q  <= data_q << 8;
            cnt     <= cnt + 5'd1;
          end
        end
        CSUM: if (accept) begin
          tx_en       <= 1'b0;
          done[owner] <= 1'b1;
          busy        <= 1'b0;
          state       <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
